// File: rtl/systolic_seq_ctrl_if.sv
// Control/handshake bundle between the tile sequencer (master) and the
// weight buffer, input buffer, systolic array edges and host (slave).
interface systolic_seq_ctrl_if #(
    parameter int IDX_W     = 4,
    parameter int VEC_CNT_W = 16
);
    logic                 start_i;
    logic [VEC_CNT_W-1:0] num_vecs_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 w_rd_en_o;
    logic [IDX_W-1:0]     w_addr_o;
    logic                 w_accept_o;
    logic [IDX_W-1:0]     w_index_o;
    logic                 sw_o;
    logic                 in_valid_o;
    logic [VEC_CNT_W-1:0] in_addr_o;
    logic                 in_ready_i;
    logic                 res_valid_i;
    logic [VEC_CNT_W-1:0] res_cnt_o;
    logic [31:0]          perf_cycles_o;
    logic [31:0]          perf_stall_o;

    modport master (
        input  start_i, num_vecs_i, in_ready_i, res_valid_i,
        output busy_o, done_o, w_rd_en_o, w_addr_o, w_accept_o, w_index_o,
               sw_o, in_valid_o, in_addr_o, res_cnt_o, perf_cycles_o, perf_stall_o
    );

    modport slave (
        output start_i, num_vecs_i, in_ready_i, res_valid_i,
        input  busy_o, done_o, w_rd_en_o, w_addr_o, w_accept_o, w_index_o,
               sw_o, in_valid_o, in_addr_o, res_cnt_o, perf_cycles_o, perf_stall_o
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the weight-stationary systolic array: weight load, settle, switch, stream, drain.
// Busy/stall performance counters are built only when SEQ_PERF_CNT_EN is defined.
module systolic_seq_ctrl #(
    parameter int ARRAY_N   = 16,
    parameter int IDX_W     = $clog2(ARRAY_N),
    parameter int VEC_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(ARRAY_N + 1);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]     LOAD_LAST   = CNT_W'(ARRAY_N - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(ARRAY_N);
    localparam logic [VEC_CNT_W-1:0] VEC_ONE     = VEC_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VEC_CNT_W-1:0] num_vecs_q, num_vecs_d;
    logic                 w_rd_en_q, w_rd_en_d;
    logic [IDX_W-1:0]     w_addr_q, w_addr_d;
    logic                 w_accept_q, w_accept_d;
    logic [IDX_W-1:0]     w_index_q, w_index_d;
    logic                 sw_q, sw_d;
    logic [VEC_CNT_W-1:0] in_addr_q, in_addr_d;
    logic [VEC_CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic start_acc_s;
    logic in_valid_s;
    logic res_inc_s;

    assign start_acc_s = (state_q == ST_IDLE) && bus.start_i;
    assign in_valid_s  = (state_q == ST_COMPUTE) && bus.in_ready_i;
    // Result beats only count while the tile is streaming or draining, saturating at num_vecs.
    assign res_inc_s   = bus.res_valid_i && (res_cnt_q != num_vecs_q) &&
                         ((state_q == ST_COMPUTE) || (state_q == ST_DRAIN));

    // Next-state and registered-output logic of the tile FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_vecs_d = num_vecs_q;
        w_rd_en_d  = 1'b0;
        w_addr_d   = {IDX_W{1'b0}};
        w_accept_d = w_rd_en_q;
        w_index_d  = w_rd_en_q ? w_addr_q : {IDX_W{1'b0}};
        sw_d       = 1'b0;
        in_addr_d  = in_valid_s ? (in_addr_q + VEC_ONE) : in_addr_q;
        res_cnt_d  = res_inc_s ? (res_cnt_q + VEC_ONE) : res_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && (bus.num_vecs_i != {VEC_CNT_W{1'b0}})) begin
                    state_d    = ST_LOAD;
                    num_vecs_d = bus.num_vecs_i;
                    res_cnt_d  = {VEC_CNT_W{1'b0}};
                    in_addr_d  = {VEC_CNT_W{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    w_rd_en_d  = 1'b1;
                end else if (bus.start_i) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    w_rd_en_d = 1'b1;
                    w_addr_d  = IDX_W'(cnt_q + CNT_ONE);
                end
            end
            // The first SETTLE cycle still carries the last lagged accept beat, hence N+1 cycles here.
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SWITCH;
                    cnt_d   = {CNT_W{1'b0}};
                    sw_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SWITCH: begin
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (in_valid_s && (in_addr_q == (num_vecs_q - VEC_ONE))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_d == num_vecs_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            num_vecs_q <= {VEC_CNT_W{1'b0}};
            w_rd_en_q  <= 1'b0;
            w_addr_q   <= {IDX_W{1'b0}};
            w_accept_q <= 1'b0;
            w_index_q  <= {IDX_W{1'b0}};
            sw_q       <= 1'b0;
            in_addr_q  <= {VEC_CNT_W{1'b0}};
            res_cnt_q  <= {VEC_CNT_W{1'b0}};
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_vecs_q <= num_vecs_d;
            w_rd_en_q  <= w_rd_en_d;
            w_addr_q   <= w_addr_d;
            w_accept_q <= w_accept_d;
            w_index_q  <= w_index_d;
            sw_q       <= sw_d;
            in_addr_q  <= in_addr_d;
            res_cnt_q  <= res_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.w_rd_en_o  = w_rd_en_q;
    assign bus.w_addr_o   = w_addr_q;
    assign bus.w_accept_o = w_accept_q;
    assign bus.w_index_o  = w_index_q;
    assign bus.sw_o       = sw_q;
    assign bus.in_valid_o = in_valid_s;
    assign bus.in_addr_o  = in_addr_q;
    assign bus.res_cnt_o  = res_cnt_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    // Saturating busy-cycle and compute-stall counters, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else if (start_acc_s) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end else begin
                perf_cycles_q <= perf_cycles_q;
            end
            if ((state_q == ST_COMPUTE) && !bus.in_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign bus.perf_cycles_o = perf_cycles_q;
    assign bus.perf_stall_o  = perf_stall_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
    assign bus.perf_cycles_o  = 32'd0;
    assign bus.perf_stall_o   = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl with ARRAY_N = 4: expected output beats are queued
// per stream when a tile is launched and a negedge monitor pops and compares them.
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int VW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.IDX_W(2), .VEC_CNT_W(VW)) bus ();

    systolic_seq_ctrl #(.ARRAY_N(N), .IDX_W(2), .VEC_CNT_W(VW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int c;
        int v;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_acc[$];
    ev_t q_sw[$];
    ev_t q_iv[$];
    ev_t q_done[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic void push(int kind, int c, int v);
        ev_t e;
        e.c = c;
        e.v = v;
        case (kind)
            0: q_rd.push_back(e);
            1: q_acc.push_back(e);
            2: q_sw.push_back(e);
            3: q_iv.push_back(e);
            default: q_done.push_back(e);
        endcase
    endfunction

    function automatic void observe(int kind, int val);
        ev_t e;
        bit have;
        string nm;
        have = 1'b0;
        e.c = 0;
        e.v = 0;
        case (kind)
            0: begin nm = "w_rd_en";    if (q_rd.size() > 0)   begin e = q_rd.pop_front();   have = 1'b1; end end
            1: begin nm = "w_accept";   if (q_acc.size() > 0)  begin e = q_acc.pop_front();  have = 1'b1; end end
            2: begin nm = "sw";         if (q_sw.size() > 0)   begin e = q_sw.pop_front();   have = 1'b1; end end
            3: begin nm = "in_valid";   if (q_iv.size() > 0)   begin e = q_iv.pop_front();   have = 1'b1; end end
            default: begin nm = "done"; if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL %s: unexpected beat at cycle %0d value %0d, required none", nm, cyc, val);
        end else if ((e.c != cyc) || (e.v != val)) begin
            n_err++;
            $display("FAIL %s: got cycle %0d value %0d, required cycle %0d value %0d",
                     nm, cyc, val, e.c, e.v);
        end
    endfunction

    function automatic void leftover(string name);
        chk(name, q_rd.size() + q_acc.size() + q_sw.size() + q_iv.size() + q_done.size(), 0);
        q_rd.delete();
        q_acc.delete();
        q_sw.delete();
        q_iv.delete();
        q_done.delete();
    endfunction

    // Weight fill, lagged accept and the switch pulse, relative to the start cycle t0.
    function automatic void push_prologue(int t0);
        for (int i = 0; i < N; i++) begin
            push(0, t0 + 1 + i, i);
            push(1, t0 + 2 + i, i);
        end
        push(2, t0 + 2 * N + 2, 1);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.w_rd_en_o)  observe(0, int'(bus.w_addr_o));
            if (bus.w_accept_o) observe(1, int'(bus.w_index_o));
            if (bus.sw_o)       observe(2, 1);
            if (bus.in_valid_o) observe(3, int'(bus.in_addr_o));
            if (bus.done_o) begin
                observe(4, 1);
                chk("busy_in_done", int'(bus.busy_o), 1);
            end
        end
    end

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.start_i     = 1'b0;
            bus.res_valid_i = 1'b0;
            bus.in_ready_i  = 1'b1;
            rst             = 1'b0;
        end
    endtask

    // Drives one tile cycle by cycle; bit k of each mask applies in relative cycle k.
    task automatic run(int nv, int len, bit [31:0] rdy_low, bit [31:0] res_m, int repulse, int rst_at);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            bus.start_i     = (k == 0) || (k == repulse);
            bus.num_vecs_i  = (k == 0) ? VW'(nv) : 16'd5;
            bus.in_ready_i  = ~rdy_low[k];
            bus.res_valid_i = res_m[k];
            rst             = (k == rst_at);
        end
    endtask

    task automatic expect_basic(int t0);
        push_prologue(t0);
        push(3, t0 + 11, 0);
        push(3, t0 + 12, 1);
        push(3, t0 + 13, 2);
        push(4, t0 + 17, 1);
    endtask

    initial begin
        int t0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.num_vecs_i  = 16'd0;
        bus.in_ready_i  = 1'b0;
        bus.res_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy",     int'(bus.busy_o), 0);
        chk("rst_done",     int'(bus.done_o), 0);
        chk("rst_w_rd_en",  int'(bus.w_rd_en_o), 0);
        chk("rst_w_accept", int'(bus.w_accept_o), 0);
        chk("rst_sw",       int'(bus.sw_o), 0);
        chk("rst_in_addr",  int'(bus.in_addr_o), 0);
        chk("rst_res_cnt",  int'(bus.res_cnt_o), 0);
        chk("rst_perf_cyc", int'(bus.perf_cycles_o), 0);
        chk("rst_perf_stl", int'(bus.perf_stall_o), 0);
        idle(2);

        // Basic tile: 3 vectors, no backpressure, results in cycles 14..16.
        t0 = cyc + 1;
        expect_basic(t0);
        run(3, 20, 32'h0, 32'h0001_C000, -1, -1);
        idle(2);
        chk("t1_res_cnt", int'(bus.res_cnt_o), 3);
        chk("t1_busy_end", int'(bus.busy_o), 0);
        leftover("t1_leftover");

        // Input backpressure in cycles 12..13.
        t0 = cyc + 1;
        push_prologue(t0);
        push(3, t0 + 11, 0);
        push(3, t0 + 14, 1);
        push(3, t0 + 15, 2);
        push(4, t0 + 17, 1);
        run(3, 20, 32'h0000_3000, 32'h0001_C000, -1, -1);
        idle(2);
        chk("t2_res_cnt", int'(bus.res_cnt_o), 3);
`ifdef SEQ_PERF_CNT_EN
        chk("t2_perf_stall", int'(bus.perf_stall_o), 2);
        chk("t2_perf_cycles", int'(bus.perf_cycles_o), 17);
`else
        chk("t2_perf_stall", int'(bus.perf_stall_o), 0);
        chk("t2_perf_cycles", int'(bus.perf_cycles_o), 0);
`endif
        leftover("t2_leftover");

        // Zero-length tile: only a done pulse.
        t0 = cyc + 1;
        push(4, t0 + 1, 1);
        run(0, 4, 32'h0, 32'h0, -1, -1);
        idle(4);
        leftover("t3_leftover");

        // Restart attempt mid-tile and surplus result beats.
        t0 = cyc + 1;
        expect_basic(t0);
        run(3, 20, 32'h0, 32'h0007_C000, 7, -1);
        idle(2);
        chk("t4_res_cnt_sat", int'(bus.res_cnt_o), 3);
        leftover("t4_leftover");

        // Reset in cycle 12 aborts the tile silently.
        t0 = cyc + 1;
        push_prologue(t0);
        push(3, t0 + 11, 0);
        push(3, t0 + 12, 1);
        run(3, 14, 32'h0, 32'h0, -1, 12);
        chk("t5_busy",     int'(bus.busy_o), 0);
        chk("t5_w_rd_en",  int'(bus.w_rd_en_o), 0);
        chk("t5_w_addr",   int'(bus.w_addr_o), 0);
        chk("t5_w_accept", int'(bus.w_accept_o), 0);
        chk("t5_w_index",  int'(bus.w_index_o), 0);
        chk("t5_sw",       int'(bus.sw_o), 0);
        chk("t5_in_valid", int'(bus.in_valid_o), 0);
        chk("t5_in_addr",  int'(bus.in_addr_o), 0);
        chk("t5_res_cnt",  int'(bus.res_cnt_o), 0);
        chk("t5_done",     int'(bus.done_o), 0);
        idle(8);
        leftover("t5_leftover");

        // Fresh tile after the abort replays the full timing.
        t0 = cyc + 1;
        expect_basic(t0);
        run(3, 20, 32'h0, 32'h0001_C000, -1, -1);
        idle(2);
        chk("t6_res_cnt", int'(bus.res_cnt_o), 3);
        leftover("t6_leftover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
